fpu_addsub_sched: RTL

- Arbitrates two issue ports onto one shared fadd_pipe instance. The adder is fully pipelined and cannot stall.
- Performs subtraction by flipping the sign bit of y before issue, so no separate fsub unit is needed.
- Carries the port ID and tag alongside each operation, then returns each result with its originating port and tag.
- Sits between the FPU dispatch logic and the adder. The adder is instantiated externally; this block drives its operands and samples its result.

---
 rtl/fpu_addsub_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fpu_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpu_addsub_sched
// Brief    : Round-robin issue of two add/sub ports onto one shared fadd_pipe,
//            returning each result with its originating port id and tag.
// Revision : 1.0
// ============================================================================
module fpu_addsub_sched #(
    parameter int LAT  = 3,
    parameter int TAGW = 4
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      p0_valid,
    output logic                      p0_ready,
    input  logic                      p0_sub,
    input  logic [31:0]               p0_x,
    input  logic [31:0]               p0_y,
    input  logic [TAGW-1:0]           p0_tag,

    input  logic                      p1_valid,
    output logic                      p1_ready,
    input  logic                      p1_sub,
    input  logic [31:0]               p1_x,
    input  logic [31:0]               p1_y,
    input  logic [TAGW-1:0]           p1_tag,

    output logic [31:0]               fa_x,
    output logic [31:0]               fa_y,
    input  logic [31:0]               fa_res,

    output logic                      res_valid,
    output logic                      res_id,
    output logic [TAGW-1:0]           res_tag,
    output logic [31:0]               res,
    output logic [$clog2(LAT+2)-1:0]  inflight
);

    localparam int                CNTW  = $clog2(LAT+2);
    localparam logic [CNTW-1:0]   c_one = CNTW'(1);

    // r_rr = 0 favours port 0 when both ports request
    logic                 r_rr;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_acc;
    logic                 w_sub;
    logic [31:0]          w_x;
    logic [31:0]          w_y;
    logic [TAGW-1:0]      w_tag;

    logic [31:0]          r_fa_x;
    logic [31:0]          r_fa_y;
    logic [LAT:0]         r_v;
    logic [LAT:0]         r_id;
    logic [TAGW-1:0]      r_tag [0:LAT];
    logic [CNTW-1:0]      r_inflight;

    assign w_gnt0 = p0_valid & (~p1_valid | ~r_rr);
    assign w_gnt1 = p1_valid & (~p0_valid |  r_rr);
    assign w_acc  = w_gnt0 | w_gnt1;

    assign w_sub  = w_gnt1 ? p1_sub : p0_sub;
    assign w_x    = w_gnt1 ? p1_x   : p0_x;
    assign w_y    = w_gnt1 ? p1_y   : p0_y;
    assign w_tag  = w_gnt1 ? p1_tag : p0_tag;

    assign p0_ready = w_gnt0;
    assign p1_ready = w_gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr       <= 1'b0;
            r_fa_x     <= 32'h0;
            r_fa_y     <= 32'h0;
            r_v        <= '0;
            r_id       <= '0;
            r_inflight <= '0;
            for (int i = 0; i <= LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_gnt0) begin
                r_rr <= 1'b1;
            end else if (w_gnt1) begin
                r_rr <= 1'b0;
            end

            // Subtraction is an add with y's sign inverted, NaN and zero included
            if (w_acc) begin
                r_fa_x <= w_x;
                r_fa_y <= {w_y[31] ^ w_sub, w_y[30:0]};
            end

            r_v[0]   <= w_acc;
            r_id[0]  <= w_gnt1;
            r_tag[0] <= w_tag;
            for (int i = 1; i <= LAT; i++) begin
                r_v[i]   <= r_v[i-1];
                r_id[i]  <= r_id[i-1];
                r_tag[i] <= r_tag[i-1];
            end

            case ({w_acc, r_v[LAT]})
                2'b10:   r_inflight <= r_inflight + c_one;
                2'b01:   r_inflight <= r_inflight - c_one;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign fa_x      = r_fa_x;
    assign fa_y      = r_fa_y;
    assign res_valid = r_v[LAT];
    assign res_id    = r_id[LAT];
    assign res_tag   = r_tag[LAT];
    assign res       = r_v[LAT] ? fa_res : 32'h0;
    assign inflight  = r_inflight;

endmodule
`default_nettype wire
